// File: rtl/risc_v_mike_pkg.sv
// risc_v_mike_pkg: shared widths, ALU opcodes and arbiter FSM states
package risc_v_mike_pkg;
  localparam int DATA_32_W  = 32;
  localparam int ALU_CTRL_W = 3;
  typedef enum logic [ALU_CTRL_W-1:0] {
    ADD = 3'd0,
    SUB = 3'd1,
    SLL = 3'd2,
    SLT = 3'd3,
    XOR = 3'd5,
    SRL = 3'd6,
    SRA = 3'd7
  } alu_op_e;
  typedef enum logic [1:0] {ARB_IDLE, ARB_EXEC, ARB_RESP} arb_state_e;
endpackage

// File: rtl/risc_v_mike_alu.sv
// risc_v_mike_alu: combinational 32-bit ALU
//  i_a, i_b  operands
//  i_ctrl    operation (alu_op_e); undefined codes return 0xDEADBEEF
//  i_signed  signed compare for SLT
//  o_result  ALU result
//  o_slt     compare outcome, valid for every op (caller masks it)
module risc_v_mike_alu
  import risc_v_mike_pkg::*;
(
  input  logic [DATA_32_W-1:0]  i_a,
  input  logic [DATA_32_W-1:0]  i_b,
  input  logic [ALU_CTRL_W-1:0] i_ctrl,
  input  logic                  i_signed,
  output logic [DATA_32_W-1:0]  o_result,
  output logic                  o_slt
);
  logic [4:0] w_sh;
  assign w_sh  = i_b[4:0];
  assign o_slt = i_signed ? ($signed(i_a) < $signed(i_b)) : (i_a < i_b);
  always_comb begin
    o_result = 32'hDEADBEEF;
    case (i_ctrl)
      ADD:     o_result = i_a + i_b;
      SUB:     o_result = i_a - i_b;
      SLL:     o_result = i_a << w_sh;
      SLT:     o_result = {31'd0, o_slt};
      XOR:     o_result = i_a ^ i_b;
      SRL:     o_result = i_a >> w_sh;
      SRA:     o_result = $unsigned($signed(i_a) >>> w_sh);
      default: o_result = 32'hDEADBEEF;
    endcase
  end
endmodule

// File: rtl/risc_v_mike_rr_arb.sv
// risc_v_mike_rr_arb: combinational round-robin pick starting at i_ptr
//  i_req  request bits
//  i_ptr  highest-priority index
//  o_gnt  one-hot grant (0 when no request)
//  o_idx  granted index
//  o_hit  any request granted
module risc_v_mike_rr_arb #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_ptr,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [ID_W-1:0]    o_idx,
  output logic               o_hit
);
  // Walk offsets from farthest to nearest so the nearest request from i_ptr wins.
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_hit = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (i_req[(int'(i_ptr) + i) % NUM_REQ]) begin
        o_gnt = '0;
        o_gnt[(int'(i_ptr) + i) % NUM_REQ] = 1'b1;
        o_idx = ID_W'((int'(i_ptr) + i) % NUM_REQ);
        o_hit = 1'b1;
      end
    end
  end
endmodule

// File: rtl/risc_v_mike_alu_arbiter.sv
// risc_v_mike_alu_arbiter: round-robin sharing of one ALU between NUM_REQ requesters
//  req_valid/req_ready   request handshake, req_ready one-hot in IDLE only
//  req_src_a/b, req_ctrl, req_signed   per-requester payload
//  rsp_valid/rsp_ready   response handshake, only the owner's bit is used
//  rsp_result/zero/slt   registered result, held until the owner takes it
//  busy, grant_id        FSM not idle, in-flight or last-granted index
module risc_v_mike_alu_arbiter
  import risc_v_mike_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_REQ-1:0]                   req_valid,
  output logic [NUM_REQ-1:0]                   req_ready,
  input  logic [NUM_REQ-1:0][DATA_32_W-1:0]    req_src_a,
  input  logic [NUM_REQ-1:0][DATA_32_W-1:0]    req_src_b,
  input  logic [NUM_REQ-1:0][ALU_CTRL_W-1:0]   req_ctrl,
  input  logic [NUM_REQ-1:0]                   req_signed,
  output logic [NUM_REQ-1:0]                   rsp_valid,
  input  logic [NUM_REQ-1:0]                   rsp_ready,
  output logic [DATA_32_W-1:0]                 rsp_result,
  output logic                                 rsp_zero,
  output logic                                 rsp_slt,
  output logic                                 busy,
  output logic [ID_W-1:0]                      grant_id
);
  arb_state_e              r_state;
  logic [ID_W-1:0]         r_rr_ptr;
  logic [ID_W-1:0]         r_id;
  logic [DATA_32_W-1:0]    r_a;
  logic [DATA_32_W-1:0]    r_b;
  logic [ALU_CTRL_W-1:0]   r_ctrl;
  logic                    r_signed;
  logic [NUM_REQ-1:0]      r_rsp_valid;
  logic [DATA_32_W-1:0]    r_result;
  logic                    r_zero;
  logic                    r_slt;
  logic [NUM_REQ-1:0]      w_gnt;
  logic [ID_W-1:0]         w_idx;
  logic                    w_hit;
  logic [DATA_32_W-1:0]    w_alu_result;
  logic                    w_alu_slt;
  risc_v_mike_rr_arb #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .i_req(req_valid),
    .i_ptr(r_rr_ptr),
    .o_gnt(w_gnt),
    .o_idx(w_idx),
    .o_hit(w_hit)
  );
  risc_v_mike_alu u_alu (
    .i_a(r_a),
    .i_b(r_b),
    .i_ctrl(r_ctrl),
    .i_signed(r_signed),
    .o_result(w_alu_result),
    .o_slt(w_alu_slt)
  );
  // rst gates the grant so nothing looks accepted while reset is held.
  assign req_ready  = (r_state == ARB_IDLE && !rst) ? w_gnt : '0;
  assign busy       = r_state != ARB_IDLE;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_result = r_result;
  assign rsp_zero   = r_zero;
  assign rsp_slt    = r_slt;
  assign grant_id   = r_id;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ARB_IDLE;
      r_rr_ptr    <= '0;
      r_id        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_ctrl      <= '0;
      r_signed    <= 1'b0;
      r_rsp_valid <= '0;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_slt       <= 1'b0;
    end else begin
      case (r_state)
        ARB_IDLE: if (w_hit) begin
          r_a      <= req_src_a[w_idx];
          r_b      <= req_src_b[w_idx];
          r_ctrl   <= req_ctrl[w_idx];
          r_signed <= req_signed[w_idx];
          r_id     <= w_idx;
          r_state  <= ARB_EXEC;
        end
        ARB_EXEC: begin
          r_result    <= w_alu_result;
          r_zero      <= w_alu_result == '0;
          r_slt       <= (r_ctrl == SLT) && w_alu_slt;
          r_rsp_valid <= NUM_REQ'(1) << r_id;
          r_state     <= ARB_RESP;
        end
        ARB_RESP: if (rsp_ready[r_id]) begin
          r_rsp_valid <= '0;
          r_rr_ptr    <= (r_id == ID_W'(NUM_REQ - 1)) ? '0 : r_id + ID_W'(1);
          r_state     <= ARB_IDLE;
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_risc_v_mike_alu_arbiter.sv
// tb_risc_v_mike_alu_arbiter: scoreboard bench with random traffic against a behavioural model
module tb_risc_v_mike_alu_arbiter;
  localparam int N = 2;
  typedef struct {
    int          id;
    logic [31:0] res;
    logic        z;
    logic        s;
    int          cyc;
  } exp_t;
  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [N-1:0]      req_valid = '0;
  logic [N-1:0]      req_ready;
  logic [N-1:0][31:0] req_src_a = '0;
  logic [N-1:0][31:0] req_src_b = '0;
  logic [N-1:0][2:0] req_ctrl = '0;
  logic [N-1:0]      req_signed = '0;
  logic [N-1:0]      rsp_valid;
  logic [N-1:0]      rsp_ready = '1;
  logic [31:0]       rsp_result;
  logic              rsp_zero, rsp_slt, busy;
  logic [0:0]        grant_id;
  int n_chk = 0, n_fail = 0, cyc = 0, mptr = 0;
  bit seen = 0;
  exp_t sb[$];
  int gids[$];

  risc_v_mike_alu_arbiter #(.NUM_REQ(N)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_src_a(req_src_a), .req_src_b(req_src_b), .req_ctrl(req_ctrl),
    .req_signed(req_signed), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_slt(rsp_slt),
    .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic lt(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint la, lb;
    la = s ? longint'($signed(a)) : longint'({32'd0, a});
    lb = s ? longint'($signed(b)) : longint'({32'd0, b});
    return la < lb;
  endfunction

  function automatic logic [31:0] mdl(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b, input logic s);
    case (c)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a << b[4:0];
      3'd3: return {31'd0, lt(a, b, s)};
      3'd5: return a ^ b;
      3'd6: return a >> b[4:0];
      3'd7: return 32'(longint'($signed(a)) >>> b[4:0]);
      default: return 32'hDEADBEEF;
    endcase
  endfunction

  task automatic put(input int i, input logic [2:0] c, input logic [31:0] a, input logic [31:0] b, input logic s);
    req_src_a[i] = a;
    req_src_b[i] = b;
    req_ctrl[i] = c;
    req_signed[i] = s;
    req_valid[i] = 1'b1;
  endtask

  // One clock: observe acceptances at the falling edge, model the grant, retire accepted requests after the rising edge.
  task automatic cycle();
    logic [N-1:0] acc;
    @(negedge clk);
    acc = rst ? '0 : req_valid & req_ready;
    chk("ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
    if (acc != '0) begin
      int g = 0, e = -1;
      logic [31:0] r;
      for (int k = 0; k < N; k++) if (acc[k]) g = k;
      for (int k = N - 1; k >= 0; k--) if (req_valid[(mptr + k) % N]) e = (mptr + k) % N;
      chk("rr_grant", 32'(g), 32'(e));
      mptr = (g + 1) % N;
      gids.push_back(g);
      r = mdl(req_ctrl[g], req_src_a[g], req_src_b[g], req_signed[g]);
      sb.push_back('{g, r, r == 32'd0,
                     req_ctrl[g] == 3'd3 && lt(req_src_a[g], req_src_b[g], req_signed[g]), cyc});
    end
    @(posedge clk);
    #1;
    req_valid = req_valid & ~acc;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((req_valid != '0 || sb.size() != 0 || busy) && n < budget) begin
      cycle();
      n++;
    end
    if (n >= budget) chk("drain_timeout", 32'(n), 32'(budget - 1));
  endtask

  always @(negedge clk) begin
    if (rst) seen = 0;
    else if (rsp_valid != '0) begin
      if (sb.size() == 0) chk("spurious_rsp", 32'(rsp_valid), 32'd0);
      else begin
        if (!seen) chk("latency", 32'(cyc - sb[0].cyc), 32'd2);
        seen = 1;
        chk("rsp_valid", 32'(rsp_valid), 32'(1 << sb[0].id));
        chk("rsp_result", rsp_result, sb[0].res);
        chk("rsp_zero", 32'(rsp_zero), 32'(sb[0].z));
        chk("rsp_slt", 32'(rsp_slt), 32'(sb[0].s));
        chk("grant_id", 32'(grant_id), 32'(sb[0].id));
        if (rsp_ready[sb[0].id]) begin
          void'(sb.pop_front());
          seen = 0;
        end
      end
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_result", rsp_result, 32'd0);
    chk("rst_zero_slt", {30'd0, rsp_zero, rsp_slt}, 32'd0);
    chk("rst_grant_busy", {30'd0, grant_id, busy}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    // ADD 5+7
    put(0, 3'd0, 32'd5, 32'd7, 1'b0);
    drain(20);
    // Simultaneous requests after reset: req0 first
    #2 rst = 1'b1;
    mptr = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    gids.delete();
    put(0, 3'd1, 32'd3, 32'd5, 1'b0);
    put(1, 3'd3, 32'hFFFFFFFF, 32'd1, 1'b1);
    drain(30);
    chk("order_first", 32'(gids[0]), 32'd0);
    chk("order_second", 32'(gids[1]), 32'd1);
    // Both requesters permanently valid: alternation
    gids.delete();
    for (int n = 0; n < 200 && gids.size() < 4; n++) begin
      for (int i = 0; i < N; i++)
        if (!req_valid[i]) put(i, 3'($urandom_range(0, 7)), $urandom, $urandom, 1'($urandom));
      cycle();
    end
    drain(30);
    for (int k = 0; k < 4; k++) chk("alternate", 32'(gids[k]), 32'(k % 2));
    // Response stall
    put(0, 3'd5, 32'h1234_5678, 32'hFFFF_0000, 1'b0);
    rsp_ready = '0;
    for (int n = 0; n < 20 && req_valid[0]; n++) cycle();
    put(1, 3'd0, 32'd1, 32'd2, 1'b0);
    for (int n = 0; n < 20 && rsp_valid == '0; n++) cycle();
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("stall_req_ready", 32'(req_ready), 32'd0);
      chk("stall_busy", 32'(busy), 32'd1);
      chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
    end
    rsp_ready = '1;
    cycle();
    chk("release_idle", 32'(busy), 32'd0);
    drain(30);
    // Reset during EXEC drops the op and restarts arbitration at req0
    put(0, 3'd0, 32'd1, 32'd1, 1'b0);
    drain(20);
    gids.delete();
    put(1, 3'd0, 32'd2, 32'd2, 1'b0);
    for (int n = 0; n < 20 && gids.size() == 0; n++) cycle();
    chk("exec_busy", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("arst_req_ready", 32'(req_ready), 32'd0);
    sb.delete();
    mptr = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) cycle();
    chk("no_rsp_after_rst", 32'(rsp_valid), 32'd0);
    gids.delete();
    put(0, 3'd2, 32'd1, 32'd4, 1'b0);
    put(1, 3'd6, 32'h8000_0000, 32'd4, 1'b0);
    drain(30);
    chk("post_rst_grant", 32'(gids[0]), 32'd0);
    // Boundary ops
    put(0, 3'd3, 32'hFFFFFFFF, 32'd1, 1'b0);
    drain(20);
    put(1, 3'd1, 32'd9, 32'd9, 1'b0);
    drain(20);
    put(0, 3'd4, 32'd1, 32'd2, 1'b0);
    drain(20);
    put(1, 3'd7, 32'h8000_0000, 32'd31, 1'b0);
    drain(20);
    // Random traffic with random response back-pressure
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < N; i++)
        if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
          logic [31:0] a;
          a = $urandom;
          put(i, 3'($urandom_range(0, 7)), a, ($urandom_range(0, 3) == 0) ? a : $urandom, 1'($urandom));
        end
      rsp_ready = N'($urandom);
      cycle();
    end
    rsp_ready = '1;
    drain(50);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got stuck expected completion");
    $fatal(1, "timeout");
  end
endmodule
